// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: 2-entry in-order result buffer feeding the
// register-file write port, plus the architectural flag register and hazard mask.
module alu_writeback #(
  parameter int DEPTH = 2,
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_uop,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [31:0]              in_result,
  input  logic [3:0]               in_flags,
  input  logic                     in_setf,
  input  logic                     flush,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [$clog2(NREGS)-1:0] wr_addr,
  output logic [31:0]              wr_data,
  output logic [3:0]               flags_q,
  output logic [NREGS-1:0]         busy_mask,
  output logic                     err_illegal
);

  localparam int AW = $clog2(NREGS);
  localparam logic [4:0] UOP_NOP = 5'd0;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_MAX = 5'd8;
  localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [4:0]    uop;
    logic [AW-1:0] rd;
    logic [31:0]   result;
    logic [3:0]    flags;
    logic          setf;
  } entry_t;

  entry_t            slot_r [2];
  entry_t            slot_s [2];
  logic              hd_r, hd_s;
  logic [1:0]        count_r, count_s;
  entry_t            head_s, next_head_s;
  logic              accept_s, retire_s, push_s;
  logic              wr_valid_s, in_ready_s, err_s;
  logic [AW-1:0]     wr_addr_s;
  logic [31:0]       wr_data_s;
  logic [3:0]        flags_s;
  logic [NREGS-1:0]  busy_s;

  // Next buffer state and the registered-output values derived from it.
  always_comb begin
    slot_s      = slot_r;
    hd_s        = hd_r;
    count_s     = count_r;
    head_s      = slot_r[hd_r];
    accept_s    = in_valid && in_ready;
    push_s      = accept_s && (in_uop != UOP_NOP) && (in_uop <= UOP_MAX) && !flush;
    retire_s    = 1'b0;
    flags_s     = flags_q;
    err_s       = err_illegal;
    busy_s      = {NREGS{1'b0}};

    // CMP heads drain without a register write; write heads wait for the port.
    if (count_r != 2'd0) begin
      if (head_s.uop == UOP_CMP) begin
        retire_s = 1'b1;
      end else begin
        retire_s = wr_ready;
      end
    end else begin
      retire_s = 1'b0;
    end

    if (retire_s && (head_s.setf || (head_s.uop == UOP_CMP))) begin
      flags_s = head_s.flags;
    end else begin
      flags_s = flags_q;
    end

    if (accept_s && (in_uop > UOP_MAX)) begin
      err_s = 1'b1;
    end else begin
      err_s = err_illegal;
    end

    if (flush) begin
      hd_s    = 1'b0;
      count_s = 2'd0;
    end else begin
      if (push_s) begin
        slot_s[hd_r ^ count_r[0]] = {in_uop, in_rd, in_result, in_flags, in_setf};
      end else begin
        slot_s[hd_r ^ count_r[0]] = slot_r[hd_r ^ count_r[0]];
      end
      hd_s    = hd_r ^ retire_s;
      count_s = count_r + {1'b0, push_s} - {1'b0, retire_s};
    end

    next_head_s = slot_s[hd_s];
    wr_valid_s  = (count_s != 2'd0) && (next_head_s.uop != UOP_CMP);
    if (wr_valid_s) begin
      wr_addr_s = next_head_s.rd;
      wr_data_s = next_head_s.result;
    end else begin
      wr_addr_s = wr_addr;
      wr_data_s = wr_data;
    end

    for (int i = 0; i < 2; i++) begin
      if ((2'(i) < count_s) && (slot_s[hd_s ^ 1'(i)].uop != UOP_CMP)) begin
        busy_s = busy_s | (ONE_HOT0 << slot_s[hd_s ^ 1'(i)].rd);
      end else begin
        busy_s = busy_s;
      end
    end

    in_ready_s = (count_s < 2'(DEPTH));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) slot_r[i] <= '0;
      hd_r        <= 1'b0;
      count_r     <= 2'd0;
      in_ready    <= 1'b1;
      wr_valid    <= 1'b0;
      wr_addr     <= {AW{1'b0}};
      wr_data     <= 32'd0;
      flags_q     <= 4'd0;
      busy_mask   <= {NREGS{1'b0}};
      err_illegal <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) slot_r[i] <= slot_s[i];
      hd_r        <= hd_s;
      count_r     <= count_s;
      in_ready    <= in_ready_s;
      wr_valid    <= wr_valid_s;
      wr_addr     <= wr_addr_s;
      wr_data     <= wr_data_s;
      flags_q     <= flags_s;
      busy_mask   <= busy_s;
      err_illegal <= err_s;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: queue-based reference model compared every
// cycle, plus literal expectations for the scenarios of interest.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_uop = 5'd0;
  logic [3:0]  in_rd = 4'd0;
  logic [31:0] in_result = 32'd0;
  logic [3:0]  in_flags = 4'd0;
  logic        in_setf = 1'b0;
  logic        flush = 1'b0;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  flags_q;
  logic [15:0] busy_mask;
  logic        err_illegal;

  int total = 0;
  int bad = 0;

  alu_writeback #(.DEPTH(2), .NREGS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_uop(in_uop), .in_rd(in_rd), .in_result(in_result), .in_flags(in_flags),
    .in_setf(in_setf), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .flags_q(flags_q),
    .busy_mask(busy_mask), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  uop;
    logic [3:0]  rd;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        setf;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  m_flags = 4'd0;
  logic        m_err = 1'b0;
  logic [3:0]  log_addr[$];
  logic [31:0] log_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order queue updated on each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_flags = 4'd0;
      m_err = 1'b0;
    end else begin
      bit acc;
      bit ret;
      acc = in_valid && (mq.size() < 2);
      ret = (mq.size() > 0) && ((mq[0].uop == 5'd5) || wr_ready);
      if (ret) begin
        if (mq[0].setf || mq[0].uop == 5'd5) m_flags = mq[0].flags;
        void'(mq.pop_front());
      end
      if (acc && in_uop >= 5'd9) m_err = 1'b1;
      if (flush) mq.delete();
      else if (acc && in_uop >= 5'd1 && in_uop <= 5'd8)
        mq.push_back('{in_uop, in_rd, in_result, in_flags, in_setf});
    end
  end

  // Record every register-file write the DUT performs.
  always @(posedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic        ev;
      logic [15:0] eb;
      ev = (mq.size() > 0) && (mq[0].uop != 5'd5);
      eb = 16'd0;
      foreach (mq[i]) if (mq[i].uop != 5'd5) eb[mq[i].rd] = 1'b1;
      check("m_in_ready", {31'd0, in_ready}, {31'd0, (mq.size() < 2)});
      check("m_wr_valid", {31'd0, wr_valid}, {31'd0, ev});
      if (ev) begin
        check("m_wr_addr", {28'd0, wr_addr}, {28'd0, mq[0].rd});
        check("m_wr_data", wr_data, mq[0].res);
      end
      check("m_busy", {16'd0, busy_mask}, {16'd0, eb});
      check("m_flags", {28'd0, flags_q}, {28'd0, m_flags});
      check("m_err", {31'd0, err_illegal}, {31'd0, m_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] u, input logic [3:0] rd, input logic [31:0] r,
                       input logic [3:0] f, input logic s);
    in_valid = 1'b1; in_uop = u; in_rd = rd; in_result = r; in_flags = f; in_setf = s;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_wr_valid"}, {31'd0, wr_valid}, 32'd0);
    check({tag, "_wr_addr"}, {28'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_flags"}, {28'd0, flags_q}, 32'd0);
    check({tag, "_busy"}, {16'd0, busy_mask}, 32'd0);
    check({tag, "_err"}, {31'd0, err_illegal}, 32'd0);
  endtask

  logic [3:0]  exp_addr [6];
  logic [31:0] exp_data [6];

  initial begin
    exp_addr = '{4'd3, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8};
    exp_data = '{32'h1, 32'h2, 32'h4000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h88};

    step(); step();
    check_reset_values("reset");
    rst_n = 1'b1;
    step();

    // 1: ADD r3, single-cycle write
    wr_ready = 1'b1;
    offer(5'd1, 4'd3, 32'h1, 4'b0000, 1'b1);
    step(); in_valid = 1'b0;
    check("t1_wr_valid", {31'd0, wr_valid}, 32'd1);
    check("t1_wr_addr", {28'd0, wr_addr}, 32'd3);
    check("t1_wr_data", wr_data, 32'h1);
    check("t1_busy", {16'd0, busy_mask}, 32'h0008);
    step();
    check("t1_flags", {28'd0, flags_q}, 32'd0);
    check("t1_busy_clr", {16'd0, busy_mask}, 32'd0);
    check("t1_wr_idle", {31'd0, wr_valid}, 32'd0);

    // 2: CMP updates flags only
    offer(5'd5, 4'd0, 32'h8000_0000, 4'b0011, 1'b1);
    step(); in_valid = 1'b0;
    check("t2_no_write", {31'd0, wr_valid}, 32'd0);
    check("t2_busy", {16'd0, busy_mask}, 32'd0);
    step();
    check("t2_flags", {28'd0, flags_q}, 32'b0011);

    // 3: stall with two entries, third offer refused
    wr_ready = 1'b0;
    offer(5'd6, 4'd1, 32'h2, 4'b0000, 1'b0);
    step();
    offer(5'd7, 4'd2, 32'h4000_0000, 4'b0000, 1'b0);
    step();
    offer(5'd8, 4'd4, 32'h1234_5678, 4'b0000, 1'b0);
    step(); step();
    check("t3_in_ready", {31'd0, in_ready}, 32'd0);
    check("t3_busy", {16'd0, busy_mask}, 32'h0006);
    check("t3_hold_addr", {28'd0, wr_addr}, 32'd1);
    check("t3_hold_data", wr_data, 32'h2);

    // 4: release; MOV enters only once a slot frees
    wr_ready = 1'b1;
    step();
    check("t4_in_ready", {31'd0, in_ready}, 32'd1);
    check("t4_addr_r2", {28'd0, wr_addr}, 32'd2);
    step(); in_valid = 1'b0;
    check("t4_addr_r4", {28'd0, wr_addr}, 32'd4);
    check("t4_busy", {16'd0, busy_mask}, 32'h0010);
    step();
    check("t4_drained", {31'd0, wr_valid}, 32'd0);

    // 5: XOR without setf, then NOP and illegal uop
    offer(5'd4, 4'd5, 32'hFFFF_FFFF, 4'b1000, 1'b0);
    step(); in_valid = 1'b0;
    step(); step();
    check("t5_flags_kept", {28'd0, flags_q}, 32'b0011);
    offer(5'd0, 4'd6, 32'h5, 4'b0000, 1'b1);
    step();
    offer(5'd9, 4'd7, 32'h6, 4'b0000, 1'b1);
    step(); in_valid = 1'b0;
    check("t5_nop_no_write", {31'd0, wr_valid}, 32'd0);
    check("t5_err", {31'd0, err_illegal}, 32'd1);
    step();

    // 6: flush while stalled
    wr_ready = 1'b0;
    offer(5'd1, 4'd6, 32'h7, 4'b0100, 1'b1);
    step();
    offer(5'd2, 4'd7, 32'h9, 4'b0100, 1'b1);
    step(); in_valid = 1'b0;
    check("t6_busy_full", {16'd0, busy_mask}, 32'h00C0);
    flush = 1'b1;
    step(); flush = 1'b0;
    check("t6_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("t6_busy", {16'd0, busy_mask}, 32'd0);
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    check("t6_flags", {28'd0, flags_q}, 32'b0011);

    // flush coinciding with an accepted write still commits it
    offer(5'd1, 4'd8, 32'h88, 4'b0100, 1'b1);
    step(); in_valid = 1'b0;
    wr_ready = 1'b1; flush = 1'b1;
    step(); flush = 1'b0;
    check("t6_commit_flags", {28'd0, flags_q}, 32'b0100);
    check("t6_commit_idle", {31'd0, wr_valid}, 32'd0);

    // asynchronous reset in the middle of a stall
    wr_ready = 1'b0;
    offer(5'd1, 4'd9, 32'hA, 4'b1111, 1'b1);
    step();
    offer(5'd3, 4'd10, 32'hB, 4'b1111, 1'b1);
    step(); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    step();
    rst_n = 1'b1;
    wr_ready = 1'b1;
    step(); step();

    check("log_count", log_addr.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < log_addr.size()) begin
        check("log_addr", {28'd0, log_addr[i]}, {28'd0, exp_addr[i]});
        check("log_data", log_data[i], exp_data[i]);
      end else begin
        check("log_missing", 32'd0, 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
